mem_subsystem: RTL
==================

Name: mem_subsystem

Overview:
- Parametrised memory subsystem between the CPU datapath and on-chip storage.
- Decodes one address space into a synchronous-read block RAM region, an IO output-register region, an IO input-register region and an unmapped region.
- Requests and responses use valid/ready handshakes with a single outstanding transaction.
- Adds a hardware RAM scrub engine, error reporting and multi-channel GPIO.

Parameters:
- DATA_W, 8, data width of RAM words and IO registers.
- ADDR_W, 16, request address width.
- RAM_AW, 11, RAM address bits; RAM depth 2**RAM_AW; RAM occupies addresses 0 .. 2**RAM_AW-1.
- IO_CH, 4, number of GPIO output registers and number of GPIO input registers.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  2  operation: 00 read, 01 write, 10 clear (write zero), 11 reserved.
- req_addr  in  ADDR_W  byte/word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for non-read ops and errors.
- rsp_err  out  1  access fault for this response.
- scrub_start  in  1  pulse: zero the entire RAM.
- scrub_busy  out  1  high while scrubbing.
- scrub_done  out  1  one-cycle pulse when the scrub completes.
- gpio_in  in  IO_CH*DATA_W  external inputs; channel i is bits [i*DATA_W +: DATA_W].
- gpio_out  out  IO_CH*DATA_W  output registers, same packing.

Behaviour:
- Address map, with IO_BASE = 2**RAM_AW:
  - [0, IO_BASE): RAM, read/write.
  - IO_BASE+i, i<IO_CH: gpio_out[i], read/write.
  - IO_BASE+IO_CH+i: gpio_in[i], read-only.
  - All addresses >= IO_BASE+2*IO_CH: unmapped.
- Errors, with no state change and rsp_rdata=0:
  - any access to an unmapped address;
  - write or clear to a gpio_in register;
  - op 11 at any address.
- Clear (op 10) writes zero to the target location.
- gpio_in passes through a 2-flop synchroniser per bit; reads return the synchronised value.
- FSM states:
  - IDLE: req_ready=1.
    - scrub_start=1 -> SCRUB. Scrub has priority over req_valid in the same cycle, and that request is not accepted.
    - Accepted RAM read -> RDWAIT.
    - Any other accepted request: the access is performed at the accept edge -> RESP.
  - RDWAIT: one cycle for RAM output register -> RESP.
  - RESP: rsp_valid=1, with rsp_rdata/rsp_err held stable until rsp_ready=1 -> IDLE. A new request can be accepted at the earliest one cycle after the response handshake.
  - SCRUB: counter runs 0 .. 2**RAM_AW-1, writing zero to one word per cycle. scrub_busy=1 and req_ready=0 throughout. After the last word: scrub_done=1 for one cycle -> IDLE.
- scrub_start outside IDLE is ignored; it is not queued.
- Latency, with the request accepted at edge N:
  - write, clear, IO read and error: rsp_valid from N+1;
  - RAM read: rsp_valid from N+2.
- RAM read data is the content at the accept edge; a later write cannot alter an in-flight read.
- Address decode uses the full ADDR_W bits with no aliasing.
- Reset, asynchronous on rst_n low:
  - outputs: req_ready=0 while rst_n low, 1 from the first clock after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, scrub_busy=0, scrub_done=0, gpio_out=0;
  - internal: synchronisers=0, FSM=IDLE, scrub counter=0.
- Reset does not initialise RAM contents. Reset mid-scrub or mid-transaction aborts it: the RAM is left partially cleared and the pending response is dropped.

Test Plan:
- Write 0xA5 to 0x0010, then read 0x0010 -> write response err=0 at N+1; read rsp_rdata=0xA5 at N+2, err=0.
- Write 0x3C to 0x0801, then read it back -> gpio_out[15:8]=0x3C the cycle after the accept edge; read returns 0x3C, err=0.
- gpio_in channel 2 set to 0x77; after ≥3 cycles read 0x0806 -> rsp_rdata=0x77. Write 0x11 to 0x0806 -> rsp_err=1, subsequent read still 0x77.
- Read 0x0808 and 0xFFFF; issue op 11 to 0x0000 -> each gives rsp_err=1, rsp_rdata=0, RAM[0] unchanged.
- Hold rsp_ready=0 for 5 cycles after a RAM read -> rsp_valid and rsp_rdata stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
- Fill 0x0000 and 0x07FF with 0xFF, pulse scrub_start with req_valid=1 in the same cycle -> request not accepted, scrub_busy for 2048 cycles, one scrub_done pulse, both locations read 0x00. Separately assert rst_n=0 mid-scrub -> scrub_busy=0 immediately, gpio_out=0.

Source files
------------

// File: rtl/mem_subsystem.sv
// mem_subsystem: memory subsystem between the CPU datapath and on-chip storage.
// Decodes one address space into a synchronous-read block RAM, GPIO output
// registers, GPIO input registers (2-flop synchronised) and an unmapped region.
// Single outstanding valid/ready transaction; hardware RAM scrub engine.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_op, req_addr, req_wdata
//   rsp_valid/rsp_ready   response handshake; rsp_rdata, rsp_err
//   scrub_start           pulse: zero the whole RAM
//   scrub_busy/scrub_done scrub in progress / one-cycle completion pulse
//   gpio_in, gpio_out     IO_CH channels of DATA_W bits, channel i at [i*DATA_W +: DATA_W]
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a request or a scrub start
// S_RDWAIT | RAM output register being loaded for an accepted RAM read
// S_RESP   | response presented, held until rsp_ready
// S_SCRUB  | writing zero to one RAM word per cycle
module mem_subsystem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int RAM_AW = 11,
    parameter int IO_CH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    input  logic                    scrub_start,
    output logic                    scrub_busy,
    output logic                    scrub_done,
    input  logic [IO_CH*DATA_W-1:0] gpio_in,
    output logic [IO_CH*DATA_W-1:0] gpio_out
);
    localparam int RAM_DEPTH = 2**RAM_AW;
    localparam int CH_W = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam logic [ADDR_W-1:0] IO_BASE = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] N_CH    = ADDR_W'(IO_CH);
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RDWAIT, S_RESP, S_SCRUB} state_t;
    state_t state, state_nxt;

    logic                         ready_en;
    logic                         accept;
    logic [ADDR_W-1:0]            io_off;
    logic [ADDR_W-1:0]            gin_off;
    logic                         is_ram, is_gout, is_gin;
    logic                         op_write;
    logic                         req_err;
    logic [DATA_W-1:0]            wr_val;
    logic [CH_W-1:0]              gout_ch, gin_ch;
    logic [IO_CH-1:0][DATA_W-1:0] gout_q, gin_s1, gin_s2;
    logic [DATA_W-1:0]            ram [RAM_DEPTH];
    logic [DATA_W-1:0]            ram_q;
    logic [RAM_AW-1:0]            scrub_cnt;
    logic                         scrub_last;
    logic                         ram_we;
    logic [RAM_AW-1:0]            ram_waddr;
    logic [DATA_W-1:0]            ram_wdata;

    // Full-width decode; the offsets wrap when below their region but are
    // only used once the lower regions have been excluded.
    assign io_off   = req_addr - IO_BASE;
    assign gin_off  = io_off - N_CH;
    assign is_ram   = req_addr < IO_BASE;
    assign is_gout  = !is_ram && (io_off < N_CH);
    assign is_gin   = !is_ram && !is_gout && (gin_off < N_CH);
    assign gout_ch  = io_off[CH_W-1:0];
    assign gin_ch   = gin_off[CH_W-1:0];
    assign op_write = (req_op == OP_WR) || (req_op == OP_CLR);
    assign req_err  = (req_op == OP_RSV) || !(is_ram || is_gout || is_gin)
                      || (is_gin && op_write);
    assign wr_val   = (req_op == OP_CLR) ? '0 : req_wdata;

    assign accept     = req_valid && req_ready;
    assign scrub_last = scrub_cnt == RAM_AW'(RAM_DEPTH - 1);
    assign gpio_out   = gout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        scrub_busy = 1'b0;
        case (state)
            S_IDLE: begin
                // scrub_start wins the cycle, so the request is held off
                req_ready = ready_en && !scrub_start;
                if (scrub_start)
                    state_nxt = S_SCRUB;
                else if (req_valid && ready_en)
                    state_nxt = (is_ram && req_op == OP_RD) ? S_RDWAIT : S_RESP;
            end
            S_RDWAIT: state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            S_SCRUB: begin
                scrub_busy = 1'b1;
                if (scrub_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            gin_s1     <= '0;
            gin_s2     <= '0;
            gout_q     <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            scrub_done <= 1'b0;
            scrub_cnt  <= '0;
        end else begin
            ready_en   <= 1'b1;
            gin_s1     <= gpio_in;
            gin_s2     <= gin_s1;
            scrub_done <= 1'b0;
            if (accept) begin
                rsp_err   <= req_err;
                rsp_rdata <= '0;
                if (!req_err) begin
                    if (is_gout && op_write) gout_q[gout_ch] <= wr_val;
                    if (req_op == OP_RD) begin
                        if (is_gout)     rsp_rdata <= gout_q[gout_ch];
                        else if (is_gin) rsp_rdata <= gin_s2[gin_ch];
                    end
                end
            end
            if (state == S_RDWAIT) rsp_rdata <= ram_q;
            if (state == S_RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
            if (state == S_SCRUB) begin
                scrub_cnt <= scrub_cnt + RAM_AW'(1);
                if (scrub_last) scrub_done <= 1'b1;
            end else begin
                scrub_cnt <= '0;
            end
        end
    end

    // Single write port shared by the scrub engine and accepted requests; the
    // two never coincide because requests are only accepted in S_IDLE.
    assign ram_we    = (state == S_SCRUB) ||
                       (accept && is_ram && op_write && !req_err);
    assign ram_waddr = (state == S_SCRUB) ? scrub_cnt : req_addr[RAM_AW-1:0];
    assign ram_wdata = (state == S_SCRUB) ? '0 : wr_val;

    // No reset on the array so it maps onto block RAM; the read is captured at
    // the accept edge so later writes cannot disturb an in-flight read.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        if (accept && is_ram) ram_q <= ram[req_addr[RAM_AW-1:0]];
    end

endmodule
